if_stage_fetch: RTL
===================

Name: if_stage_fetch

Overview:
- Fetch stage of the 5-stage pipeline: PC register, instruction-memory request, and the IF/ID pipeline register.
- Sits directly upstream of the hazard unit. It consumes that unit's PCWrite/IFIDWrite stall controls and the EX-stage branch redirect.
- Produces the IF/ID fields that ID decodes, with bubble insertion on flush, memory wait and halt.
- Also keeps saturating performance counters.

Parameters:
- PC_WIDTH, 32, width of PC and addresses
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per fetched instruction
- HALT_INSTR, 32'hFFFF_FFFF, encoding that halts fetch
- CNT_WIDTH, 16, width of performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- PCWrite  in  1  from hazard unit; 0 = hold PC
- IFIDWrite  in  1  from hazard unit; 0 = hold IF/ID register
- branch_taken  in  1  EX-stage redirect request
- branch_target  in  PC_WIDTH  redirect address
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_WIDTH  fetch address (equals PC register)
- imem_rdata  in  INSTR_WIDTH  instruction for imem_addr
- imem_ready  in  1  imem_rdata valid this cycle (same-cycle or later)
- ifid_instr  out  INSTR_WIDTH  registered instruction (0 = NOP when bubble)
- ifid_pc  out  PC_WIDTH  registered PC of ifid_instr
- ifid_pc_plus  out  PC_WIDTH  registered PC+PC_STEP
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch FSM in HALT
- stall_cnt  out  CNT_WIDTH  cycles held by hazard stall, saturating
- fetch_cnt  out  CNT_WIDTH  instructions loaded into IF/ID, saturating

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC.
  - ifid_instr/ifid_pc/ifid_pc_plus=0, ifid_valid=0.
  - Counters=0; FSM=BOOT; imem_req=0; halted=0.
- FSM states BOOT, RUN, HALT:
  - BOOT: one cycle with imem_req=0 and IF/ID loaded with a bubble, then RUN.
  - RUN: imem_req=1. Goes to HALT when an instruction equal to HALT_INSTR is loaded into IF/ID.
  - HALT: imem_req=0, PC held, IF/ID loads bubbles each cycle. Exits to RUN only on branch_taken (target applied as a flush). Otherwise exits only on reset.
- Per-cycle priority in RUN (highest first):
  1. branch_taken=1:
     - PC<=branch_target; IF/ID<=bubble (instr 0, valid 0).
     - Stall controls are ignored; the imem response this cycle is discarded.
  2. PCWrite=0 or IFIDWrite=0:
     - PC and all IF/ID fields hold; stall_cnt increments.
     - Either signal low holds both.
  3. imem_ready=0: PC holds; IF/ID<=bubble, so ID never re-executes the previous instruction.
  4. Otherwise:
     - IF/ID<={imem_rdata, PC, PC+PC_STEP, valid=1}.
     - PC<=PC+PC_STEP; fetch_cnt increments.
- Bubble: ifid_instr=0 (NOP), ifid_valid=0. ifid_pc/ifid_pc_plus are also 0.
- PC arithmetic: modulo 2^PC_WIDTH; the wrap from max to 0 is silent.
- Counters:
  - Saturate at all-ones; no wrap.
  - stall_cnt counts only priority-2 cycles in RUN.
  - fetch_cnt counts every real load, including the HALT_INSTR load.
- The HALT_INSTR load itself sets ifid_valid=1, so ID sees the halt. halted asserts the next cycle.
- A stall in the same cycle as the halt instruction arriving means the halt is not loaded; the FSM stays in RUN.
- imem_addr is the PC register output, so there is no combinational path from stall inputs to imem_addr.
- imem_req is a function of FSM state only.
- Latency: instruction at PC appears on ifid_* one cycle after the edge where imem_ready=1 and no stall/flush.
- Reset mid-operation: all state returns to reset values immediately, regardless of FSM state or a pending memory wait.

Test Plan:
- Reset release, imem_ready=1, rdata=PC-derived:
  - Cycle 1 is BOOT (imem_req=0).
  - Then ifid_pc sequence 0,4,8,...; ifid_valid=1; fetch_cnt=3 after three loads.
- PCWrite=0, IFIDWrite=0 for 2 cycles with ifid_pc=8 → ifid_pc/ifid_instr stay 8/same for 2 cycles, imem_addr stays 12, stall_cnt=2; fetch then resumes at 12.
- imem_ready=0 for 3 cycles at PC=16 → three bubbles (ifid_valid=0, ifid_instr=0), imem_addr stays 16, then ifid_pc=16 valid.
- branch_taken=1 with target 0x40 while PCWrite=0 and imem_ready=1 → next cycle imem_addr=0x40, IF/ID is a bubble, stall_cnt unchanged; following load has ifid_pc=0x40.
- HALT_INSTR fetched at PC=0x20:
  - ifid_instr=0xFFFFFFFF with valid=1, next cycle halted=1, imem_req=0, then bubbles.
  - branch_taken with target 0x100 returns to RUN, fetching 0x100.
- Saturation and reset:
  - Preload stalls until stall_cnt=0xFFFF; one more stall keeps 0xFFFF.
  - Assert rst_n=0 mid-memory-wait → all outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/if_stage_fetch.sv
// -----------------------------------------------------------------------------
// if_stage_fetch
//   Instruction-fetch stage of the 5-stage pipeline. Holds the PC, issues the
//   instruction-memory request and owns the IF/ID pipeline register. A small
//   BOOT/RUN/HALT state machine gates fetching, and two saturating counters
//   record hazard-stall cycles and real instruction loads.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   PCWrite         : hazard unit, 0 holds the PC (and IF/ID)
//   IFIDWrite       : hazard unit, 0 holds IF/ID (and the PC)
//   branch_taken    : EX-stage redirect request
//   branch_target   : redirect address
//   imem_req        : fetch request valid (decoded from FSM state only)
//   imem_addr       : fetch address, the PC register itself
//   imem_rdata      : instruction returned for imem_addr
//   imem_ready      : imem_rdata valid this cycle
//   ifid_instr      : IF/ID instruction, 0 (NOP) for a bubble
//   ifid_pc         : IF/ID PC of ifid_instr, 0 for a bubble
//   ifid_pc_plus    : IF/ID PC + PC_STEP, 0 for a bubble
//   ifid_valid      : IF/ID holds a real instruction
//   halted          : FSM is in HALT
//   stall_cnt       : saturating count of hazard-stall cycles in RUN
//   fetch_cnt       : saturating count of real IF/ID loads
// -----------------------------------------------------------------------------
module if_stage_fetch #(
  parameter int unsigned                PC_WIDTH    = 32,
  parameter int unsigned                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = {PC_WIDTH{1'b0}},
  parameter int unsigned                PC_STEP     = 4,
  parameter logic [INSTR_WIDTH-1:0]     HALT_INSTR  = 32'hFFFF_FFFF,
  parameter int unsigned                CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IFIDWrite,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus,
  output logic                   ifid_valid,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  output logic [CNT_WIDTH-1:0]   fetch_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]    PC_STEP_V = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0]    PC_ZERO   = {PC_WIDTH{1'b0}};
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = {INSTR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  state_t                 state_r, state_next_s;
  logic [PC_WIDTH-1:0]    pc_r, pc_next_s, pc_plus_s;
  logic [INSTR_WIDTH-1:0] ifid_instr_r, ifid_instr_next_s;
  logic [PC_WIDTH-1:0]    ifid_pc_r, ifid_pc_next_s;
  logic [PC_WIDTH-1:0]    ifid_pc_plus_r, ifid_pc_plus_next_s;
  logic                   ifid_valid_r, ifid_valid_next_s;
  logic [CNT_WIDTH-1:0]   stall_cnt_r, stall_cnt_next_s;
  logic [CNT_WIDTH-1:0]   fetch_cnt_r, fetch_cnt_next_s;
  logic                   req_r, halted_r;
  logic                   stall_s;

  // Either hazard control being low freezes both PC and IF/ID.
  assign stall_s   = ~PCWrite | ~IFIDWrite;
  // Modulo 2^PC_WIDTH; the wrap past the top address is intentional.
  assign pc_plus_s = pc_r + PC_STEP_V;

  // Next-state, PC, IF/ID and counter selection by FSM state and priority.
  always_comb begin
    state_next_s        = state_r;
    pc_next_s           = pc_r;
    ifid_instr_next_s   = ifid_instr_r;
    ifid_pc_next_s      = ifid_pc_r;
    ifid_pc_plus_next_s = ifid_pc_plus_r;
    ifid_valid_next_s   = ifid_valid_r;
    stall_cnt_next_s    = stall_cnt_r;
    fetch_cnt_next_s    = fetch_cnt_r;

    case (state_r)
      ST_BOOT: begin
        ifid_instr_next_s   = NOP_INSTR;
        ifid_pc_next_s      = PC_ZERO;
        ifid_pc_plus_next_s = PC_ZERO;
        ifid_valid_next_s   = 1'b0;
        state_next_s        = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stalls; this cycle's memory response is dropped.
          pc_next_s           = branch_target;
          ifid_instr_next_s   = NOP_INSTR;
          ifid_pc_next_s      = PC_ZERO;
          ifid_pc_plus_next_s = PC_ZERO;
          ifid_valid_next_s   = 1'b0;
        end else if (stall_s) begin
          stall_cnt_next_s = sat_inc(stall_cnt_r);
        end else if (!imem_ready) begin
          // Bubble rather than hold, so ID never re-executes the last instruction.
          ifid_instr_next_s   = NOP_INSTR;
          ifid_pc_next_s      = PC_ZERO;
          ifid_pc_plus_next_s = PC_ZERO;
          ifid_valid_next_s   = 1'b0;
        end else begin
          ifid_instr_next_s   = imem_rdata;
          ifid_pc_next_s      = pc_r;
          ifid_pc_plus_next_s = pc_plus_s;
          ifid_valid_next_s   = 1'b1;
          pc_next_s           = pc_plus_s;
          fetch_cnt_next_s    = sat_inc(fetch_cnt_r);
          if (imem_rdata == HALT_INSTR) begin
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        ifid_instr_next_s   = NOP_INSTR;
        ifid_pc_next_s      = PC_ZERO;
        ifid_pc_plus_next_s = PC_ZERO;
        ifid_valid_next_s   = 1'b0;
        if (branch_taken) begin
          pc_next_s    = branch_target;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: begin
        ifid_instr_next_s   = NOP_INSTR;
        ifid_pc_next_s      = PC_ZERO;
        ifid_pc_plus_next_s = PC_ZERO;
        ifid_valid_next_s   = 1'b0;
        state_next_s        = ST_BOOT;
      end
    endcase
  end

  // State, PC, IF/ID and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_BOOT;
      pc_r           <= RESET_PC;
      ifid_instr_r   <= NOP_INSTR;
      ifid_pc_r      <= PC_ZERO;
      ifid_pc_plus_r <= PC_ZERO;
      ifid_valid_r   <= 1'b0;
      stall_cnt_r    <= CNT_ZERO;
      fetch_cnt_r    <= CNT_ZERO;
      req_r          <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      pc_r           <= pc_next_s;
      ifid_instr_r   <= ifid_instr_next_s;
      ifid_pc_r      <= ifid_pc_next_s;
      ifid_pc_plus_r <= ifid_pc_plus_next_s;
      ifid_valid_r   <= ifid_valid_next_s;
      stall_cnt_r    <= stall_cnt_next_s;
      fetch_cnt_r    <= fetch_cnt_next_s;
      // Registered state decodes: always equal to (state_r == RUN/HALT).
      req_r          <= (state_next_s == ST_RUN);
      halted_r       <= (state_next_s == ST_HALT);
    end
  end

  assign imem_req     = req_r;
  assign imem_addr    = pc_r;
  assign ifid_instr   = ifid_instr_r;
  assign ifid_pc      = ifid_pc_r;
  assign ifid_pc_plus = ifid_pc_plus_r;
  assign ifid_valid   = ifid_valid_r;
  assign halted       = halted_r;
  assign stall_cnt    = stall_cnt_r;
  assign fetch_cnt    = fetch_cnt_r;

endmodule
